// File: rtl/wptr_ctrl.sv
// Write-side pointer and flag controller for a dual-clock FIFO (write clock domain only).
// Produces the RAM write strobe/address, Gray pointer for the read-side synchroniser, fill level and overflow status.
module wptr_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int AFULL_LVL = 6,
  parameter int DROP_W    = 8
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              w_en,
  input  logic              clr_ovf,
  input  logic [ADDR_W:0]   g_rptr_sync,
  output logic              w_ack,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   b_wptr,
  output logic [ADDR_W:0]   g_wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int PW = ADDR_W + 1;
  // Gray pointers differ in their top two bits exactly when the FIFO is full
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

  logic [PW-1:0] b_wptr_next;
  logic [PW-1:0] g_wptr_next;
  logic [PW-1:0] b_rptr;
  logic [PW-1:0] wlevel_next;
  logic          full_next;
  logic          afull_next;
  logic          reject;

  assign w_ack       = w_en & ~full;
  assign reject      = w_en & full;
  assign waddr       = b_wptr[ADDR_W-1:0];
  assign b_wptr_next = b_wptr + PW'(w_ack);
  assign g_wptr_next = b_wptr_next ^ (b_wptr_next >> 1);

  always_comb begin
    b_rptr = '0;
    b_rptr[PW-1] = g_rptr_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b_rptr[i] = b_rptr[i+1] ^ g_rptr_sync[i];
  end

  assign wlevel_next = b_wptr_next - b_rptr;
  assign full_next   = (g_wptr_next == (g_rptr_sync ^ FULL_MASK));
  assign afull_next  = (wlevel_next >= PW'(AFULL_LVL));

  always_ff @(posedge wclk) begin
    if (wrst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      wlevel      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      b_wptr      <= b_wptr_next;
      g_wptr      <= g_wptr_next;
      wlevel      <= wlevel_next;
      full        <= full_next;
      almost_full <= afull_next;
    end
  end

  // A reject in the same cycle as a clear counts as the first drop after the clear
  always_ff @(posedge wclk) begin
    if (wrst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= reject;
      drop_cnt <= DROP_W'(reject);
    end else if (reject) begin
      overflow <= 1'b1;
      if (~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wptr_ctrl.sv
// Directed bench for wptr_ctrl: reset, fill, overflow, wrap, clear race, saturation and mid-fill reset.
module tb_wptr_ctrl;

  logic       wclk = 1'b0;
  logic       wrst, w_en, clr_ovf;
  logic [3:0] g_rptr_sync;

  logic       w_ack, full, almost_full, overflow;
  logic [2:0] waddr;
  logic [3:0] b_wptr, g_wptr, wlevel;
  logic [7:0] drop_cnt;

  logic       s_w_ack, s_full, s_almost_full, s_overflow;
  logic [2:0] s_waddr;
  logic [3:0] s_b_wptr, s_g_wptr, s_wlevel;
  logic [1:0] s_drop_cnt;

  int passed = 0;
  int total  = 0;

  always #5 wclk = ~wclk;

  wptr_ctrl #(.ADDR_W(3), .AFULL_LVL(6), .DROP_W(8)) u_dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .clr_ovf(clr_ovf), .g_rptr_sync(g_rptr_sync),
    .w_ack(w_ack), .waddr(waddr), .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
    .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Narrow drop counter copy shares stimulus to exercise saturation
  wptr_ctrl #(.ADDR_W(3), .AFULL_LVL(6), .DROP_W(2)) u_sat (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .clr_ovf(clr_ovf), .g_rptr_sync(g_rptr_sync),
    .w_ack(s_w_ack), .waddr(s_waddr), .b_wptr(s_b_wptr), .g_wptr(s_g_wptr), .full(s_full),
    .almost_full(s_almost_full), .wlevel(s_wlevel), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b1; w_en = 1'b1; clr_ovf = 1'b0; g_rptr_sync = 4'b0000;

    // 1 reset with w_en held high
    step(); step();
    chk("rst_b_wptr", b_wptr, 0);
    chk("rst_g_wptr", g_wptr, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_w_ack_en", w_ack, 1);
    w_en = 1'b0; #1;
    chk("rst_w_ack_idle", w_ack, 0);

    // 2 fill eight entries
    wrst = 1'b0; w_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("fill%0d_b_wptr", k), b_wptr, k);
      chk($sformatf("fill%0d_wlevel", k), wlevel, k);
      chk($sformatf("fill%0d_afull", k), almost_full, (k >= 6) ? 1 : 0);
      chk($sformatf("fill%0d_full", k), full, (k == 8) ? 1 : 0);
    end
    chk("fill_g_wptr", g_wptr, 4'b1100);
    chk("fill_waddr", waddr, 0);

    // 3 overflow while full
    chk("ovf_w_ack", w_ack, 0);
    step(); step(); step();
    chk("ovf_b_wptr", b_wptr, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 3);
    chk("ovf_sat_drop", s_drop_cnt, 3);
    w_en = 1'b0; clr_ovf = 1'b1;
    step();
    chk("clr_flag", overflow, 0);
    chk("clr_drop", drop_cnt, 0);
    clr_ovf = 1'b0;

    // 4 read side releases all 8, then refill across the wrap
    g_rptr_sync = 4'b1100;
    step();
    chk("rel_full", full, 0);
    chk("rel_wlevel", wlevel, 0);
    chk("rel_afull", almost_full, 0);
    w_en = 1'b1;
    for (int k = 1; k <= 7; k++) step();
    chk("wrap_b_wptr15", b_wptr, 15);
    chk("wrap_g_wptr15", g_wptr, 4'b1000);
    chk("wrap_full7", full, 0);
    step();
    chk("wrap_b_wptr0", b_wptr, 0);
    chk("wrap_g_wptr0", g_wptr, 0);
    chk("wrap_full", full, 1);
    chk("wrap_wlevel", wlevel, 8);
    chk("wrap_afull", almost_full, 1);

    // 5 five rejects, then reject + clear in the same cycle
    for (int k = 1; k <= 5; k++) step();
    chk("race_pre_drop", drop_cnt, 5);
    chk("race_pre_ovf", overflow, 1);
    chk("sat_drop", s_drop_cnt, 3);
    chk("race_b_wptr", b_wptr, 0);
    clr_ovf = 1'b1;
    step();
    chk("race_ovf", overflow, 1);
    chk("race_drop", drop_cnt, 1);
    chk("race_sat_drop", s_drop_cnt, 1);
    clr_ovf = 1'b0;

    // 6 settle at level 5 (read bin 11 = Gray 1110), then reset mid-fill
    w_en = 1'b0; g_rptr_sync = 4'b1110;
    step();
    chk("mid_wlevel", wlevel, 5);
    chk("mid_afull", almost_full, 0);
    chk("mid_full", full, 0);
    chk("mid_ovf", overflow, 1);
    wrst = 1'b1;
    step();
    chk("mrst_b_wptr", b_wptr, 0);
    chk("mrst_g_wptr", g_wptr, 0);
    chk("mrst_wlevel", wlevel, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_full", full, 0);
    wrst = 1'b0; g_rptr_sync = 4'b0000; w_en = 1'b1; #1;
    chk("resume_waddr0", waddr, 0);
    chk("resume_w_ack", w_ack, 1);
    step();
    chk("resume_waddr1", waddr, 1);
    chk("resume_wlevel", wlevel, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
